// File: rtl/rns_reverse_conv.sv
// rtl/rns_reverse_conv.sv - two-residue RNS to binary converter, sequential shift-add CRT
module rns_reverse_conv #(
  parameter logic [8:0] MOD_A = 9'd129,
  parameter logic [8:0] MOD_B = 9'd256,
  parameter logic [7:0] INV_B = 8'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] rns_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] int_out,
  output logic        range_err
);

  // The high residue is carried through untouched as the low byte of X.
  localparam int B_BITS = $clog2(MOD_B);

  typedef enum logic [2:0] {IDLE, REDUCE, MUL, COMBINE, DONE} state_t;

  state_t            state;
  logic [7:0]        r_a;
  logic [B_BITS-1:0] r_b;
  logic              range_err_q;
  logic [8:0]        d;
  logic [8:0]        acc;
  logic [2:0]        cnt;

  logic [8:0] rb_ext;
  logic [8:0] rbm;
  logic [8:0] ra_ext;
  logic [8:0] d_diff;
  logic [8:0] d_next;
  logic [8:0] dbl;
  logic [8:0] dbl_m;
  logic [8:0] addend;
  logic [8:0] sum;
  logic [8:0] acc_next;

  // Datapath: reduce r_b into the MOD_A domain, form d = r_a - r_b mod MOD_A,
  // and one MSB-first shift-add step of k = d * INV_B mod MOD_A.
  always_comb begin
    rb_ext   = {1'b0, r_b};
    rbm      = (rb_ext >= MOD_A) ? rb_ext - MOD_A : rb_ext;
    ra_ext   = {1'b0, r_a};
    d_diff   = ra_ext - rbm;
    d_next   = (ra_ext < rbm) ? d_diff + MOD_A : d_diff;
    dbl      = acc << 1;
    dbl_m    = (dbl >= MOD_A) ? dbl - MOD_A : dbl;
    addend   = INV_B[cnt] ? d : 9'd0;
    sum      = dbl_m + addend;
    acc_next = (sum >= MOD_A) ? sum - MOD_A : sum;
  end

  // Control FSM with registered handshake and result outputs; flush wins over everything but reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      int_out     <= 16'd0;
      range_err   <= 1'b0;
      range_err_q <= 1'b0;
      r_a         <= 8'd0;
      r_b         <= '0;
      d           <= 9'd0;
      acc         <= 9'd0;
      cnt         <= 3'd0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r_a         <= rns_in[7:0];
            r_b         <= rns_in[15:8];
            range_err_q <= ({1'b0, rns_in[7:0]} >= MOD_A);
            in_ready    <= 1'b0;
            state       <= REDUCE;
          end
        end
        REDUCE: begin
          d     <= d_next;
          acc   <= 9'd0;
          cnt   <= 3'd7;
          state <= MUL;
        end
        MUL: begin
          acc <= acc_next;
          if (cnt == 3'd0) begin
            state <= COMBINE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        COMBINE: begin
          int_out   <= range_err_q ? 16'd0 : {acc[7:0], r_b};
          range_err <= range_err_q;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rns_reverse_conv.sv
// tb/tb_rns_reverse_conv.sv - scoreboard bench for rns_reverse_conv against a CRT search model
module tb_rns_reverse_conv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] rns_in = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] int_out;
  logic        range_err;

  rns_reverse_conv dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rns_in    (rns_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .int_out   (int_out),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] exp;
    int          acc_cyc;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    rand_ready = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: X is the unique value in 0..129*256-1 with X%256==r_b and X%129==r_a.
  function automatic logic [16:0] ref_model(input logic [15:0] v);
    int ra, rb;
    ra = v[7:0];
    rb = v[15:8];
    if (ra >= 129) return {1'b1, 16'd0};
    for (int k = 0; k < 129; k++) begin
      if (((rb + 256 * k) % 129) == ra) return {1'b0, 16'(rb + 256 * k)};
    end
    return {1'b1, 16'hFFFF};
  endfunction

  // Present one residue pair; optionally register its expected result with the scoreboard.
  task automatic send(input logic [15:0] v, input logic [16:0] exp, input bit push);
    int n;
    item_t it;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    rns_in   = v;
    in_valid = 1'b1;
    if (push) begin
      it.exp     = exp;
      it.acc_cyc = cyc + 1;
      sb.push_back(it);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rns_in   = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: compare every presented result against the scoreboard head, pop on handshake.
  bit first_seen = 1'b1;
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("int_out", int_out, sb[0].exp[15:0]);
        chk("range_err", range_err, sb[0].exp[16]);
        chk("in_ready_in_done", in_ready, 0);
        if (first_seen) begin
          chk("latency", cyc - sb[0].acc_cyc, 10);
          first_seen = 1'b0;
        end
        if (out_ready) begin
          void'(sb.pop_front());
          first_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    int n;
    logic [15:0] v;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_int_out", int_out, 0);
    chk("rst_range_err", range_err, 0);
    reset = 1'b0;

    send(16'h2C2A, {1'b0, 16'd300}, 1'b1);
    send(16'hFF80, {1'b0, 16'd33023}, 1'b1);
    send(16'h0000, {1'b0, 16'd0}, 1'b1);
    send(16'h8100, {1'b0, 16'd129}, 1'b1);
    send(16'h1085, {1'b1, 16'd0}, 1'b1);
    drain();
    chk("model_1085", ref_model(16'h1085), {1'b1, 16'd0});

    // Backpressure: result must hold while out_ready stays low.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(16'h2C2A, {1'b0, 16'd300}, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_int_out", int_out, 300);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_in_ready", in_ready, 1);
    chk("hold_release_out_valid", out_valid, 0);

    // Flush during the fourth MUL cycle discards the conversion.
    send(16'h2C2A, 17'd0, 1'b0);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    repeat (15) @(negedge clk);
    send(16'h2C2A, {1'b0, 16'd300}, 1'b1);
    drain();

    // Flush with in_valid in IDLE must not accept.
    @(negedge clk);
    rns_in   = 16'h2C2A;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_idle_in_ready", in_ready, 1);

    // Asynchronous reset between edges while in MUL.
    send(16'hFF80, 17'd0, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("areset_in_ready", in_ready, 1);
    chk("areset_out_valid", out_valid, 0);
    chk("areset_int_out", int_out, 0);
    chk("areset_range_err", range_err, 0);
    #1;
    reset = 1'b0;
    send(16'h2C2A, {1'b0, 16'd300}, 1'b1);
    drain();

    // Strided sweep of X plus the top value, random backpressure.
    rand_ready = 1'b1;
    for (int x = 0; x < 33024; x += 13) begin
      v = {8'(x % 256), 8'(x % 129)};
      send(v, {1'b0, 16'(x)}, 1'b1);
    end
    send({8'(33023 % 256), 8'(33023 % 129)}, {1'b0, 16'd33023}, 1'b1);

    // Raw random residue pairs, including out-of-range r_a.
    for (int i = 0; i < 300; i++) begin
      v = 16'($urandom);
      send(v, ref_model(v), 1'b1);
    end
    drain();
    rand_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=<2000000", $time);
    $fatal(1);
  end

endmodule
